cordic_merge_seq: RTL and testbench

- Iterative controller that time-multiplexes one shift-add unit to perform the CORDIC merge stage (iterations 9..16) serially.
- Accepts an operand pair X9/Y9 plus 8 direction bits through a valid/ready handshake and runs one iteration per clock.
- Returns saturated X17/Y17 through a valid/ready handshake.
- Sits between the iteration-8 pipeline output and the final-stage consumer; it is the area-reduced alternative to the fully parallel merge.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_sat_addsub.sv | 36 +++
 rtl/cordic_merge_seq.sv | 142 ++++++++++++++
 tb/tb_cordic_merge_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the serial CORDIC merge stage: default datapath
// width, saturation limits, controller states and direction-bit indexing.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 22;

    // Clamp limits of a CORDIC_WIDTH-bit two's-complement value.
    localparam logic signed [CORDIC_WIDTH-1:0] SAT_MAX = {1'b0, {(CORDIC_WIDTH-1){1'b1}}};
    localparam logic signed [CORDIC_WIDTH-1:0] SAT_MIN = {1'b1, {(CORDIC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Iteration k consumes direction bit NSTEP-1-k (MSB pairs with the
    // smallest shift).
    function automatic int dir_idx(input int nstep, input int k);
        return nstep - 1 - k;
    endfunction

endpackage

// File: rtl/cordic_sat_addsub.sv
// Combinational WIDTH-bit add or subtract, evaluated one bit wider and
// clamped back into the signed WIDTH-bit range.
module cordic_sat_addsub
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH,
    parameter bit SUB   = 1'b0
) (
    input  logic signed [WIDTH-1:0] a_in,
    input  logic signed [WIDTH-1:0] b_in,
    output logic signed [WIDTH-1:0] res_out
);

    localparam logic signed [WIDTH:0] LIM_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] LIM_MIN = {2'b11, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] full;

    assign a_ext = {a_in[WIDTH-1], a_in};
    assign b_ext = {b_in[WIDTH-1], b_in};

    // Wide sum/difference, then clamp to the representable range.
    always_comb begin
        full = SUB ? (a_ext - b_ext) : (a_ext + b_ext);
        if (full > LIM_MAX) begin
            res_out = LIM_MAX[WIDTH-1:0];
        end else if (full < LIM_MIN) begin
            res_out = LIM_MIN[WIDTH-1:0];
        end else begin
            res_out = full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cordic_merge_seq.sv
// Serial CORDIC merge stage: one shared shift/add-with-saturation unit runs
// merged iterations SHIFT_BASE..SHIFT_BASE+NSTEP-1, one per clock, with
// valid/ready handshakes on both sides.
module cordic_merge_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH      = CORDIC_WIDTH,
    parameter int NSTEP      = 8,
    parameter int SHIFT_BASE = 9,
    localparam int SW        = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic        [NSTEP-1:0] b_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    busy,
    output logic           [SW-1:0] step
);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] x0_q, x0_d, y0_q, y0_d;
    logic signed [WIDTH-1:0] xa_q, xa_d, ya_q, ya_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic        [NSTEP-1:0] bq_q, bq_d;
    logic           [SW-1:0] step_q, step_d;

    // Shift amount and operands: shifts always come from the latched inputs,
    // not the accumulators (the merge approximation).
    logic              [7:0] shamt;
    logic signed [WIDTH-1:0] x_sh, y_sh;
    logic signed [WIDTH-1:0] x_new, y_new;
    logic signed [WIDTH-1:0] xa_step, ya_step;
    logic           [SW-1:0] dir_sel;
    logic                    d_bit;
    logic                    last_step;

    assign shamt     = 8'(SHIFT_BASE) + 8'(step_q);
    assign x_sh      = x0_q >>> shamt;
    assign y_sh      = y0_q >>> shamt;
    assign dir_sel   = SW'(dir_idx(NSTEP, int'(step_q)));
    assign d_bit     = bq_q[dir_sel];
    assign last_step = (step_q == SW'(NSTEP - 1));

    cordic_sat_addsub #(.WIDTH(WIDTH), .SUB(1'b1)) u_x_sub (
        .a_in    (xa_q),
        .b_in    (y_sh),
        .res_out (x_new)
    );

    cordic_sat_addsub #(.WIDTH(WIDTH), .SUB(1'b0)) u_y_add (
        .a_in    (ya_q),
        .b_in    (x_sh),
        .res_out (y_new)
    );

    assign xa_step = d_bit ? x_new : xa_q;
    assign ya_step = d_bit ? y_new : ya_q;

    // Next-state logic: accept in IDLE, iterate in ITER, hand off in DONE.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        bq_d    = bq_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        step_d  = step_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x0_d    = x_in;
                    y0_d    = y_in;
                    bq_d    = b_in;
                    xa_d    = x_in;
                    ya_d    = y_in;
                    step_d  = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                xa_d = xa_step;
                ya_d = ya_step;
                if (last_step) begin
                    x_out_d = xa_step;
                    y_out_d = ya_step;
                    step_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            bq_q    <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            step_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            bq_q    <= bq_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            step_q  <= step_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ITER) || (state_q == ST_DONE);
    assign step      = step_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;

endmodule

// File: tb/tb_cordic_merge_seq.sv
// Self-checking bench for cordic_merge_seq: directed vectors, backpressure,
// ignored requests, mid-operation reset, back-to-back throughput and random
// operands against an arithmetic reference model.
module tb_cordic_merge_seq;

    localparam int W  = 22;
    localparam int N  = 8;
    localparam int SB = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [N-1:0] b_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic         busy;
    logic [2:0]   step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_merge_seq #(.WIDTH(W), .NSTEP(N), .SHIFT_BASE(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .busy      (busy),
        .step      (step)
    );

    // Floor division (rounds toward minus infinity), d > 0.
    function automatic longint fdiv(input longint v, input longint d);
        longint q;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clampw(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: merged iterations from the original operands, clamped each step.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [N-1:0] b,
                         output logic [W-1:0] xo, output logic [W-1:0] yo);
        longint x0, y0, xa, ya, dv;
        x0 = longint'($signed(x));
        y0 = longint'($signed(y));
        xa = x0;
        ya = y0;
        for (int k = 0; k < N; k++) begin
            dv = longint'(1) <<< (SB + k);
            if (b[N-1-k]) begin
                xa = clampw(xa - fdiv(y0, dv));
                ya = clampw(ya + fdiv(x0, dv));
            end
        end
        xo = W'(xa);
        yo = W'(ya);
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL %s wait_ready: in_ready=%0b required=1 after %0d cycles", tag, in_ready, cnt);
        end
    endtask

    // One transaction: accept, check latency/result, optional backpressure
    // hold and optional in_valid pokes while iterating, then drain.
    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [N-1:0] b,
                           input logic [W-1:0] ex, input logic [W-1:0] ey,
                           input int hold, input bit poke, input string tag);
        int cnt;
        wait_ready(tag);
        out_ready = (hold == 0);
        x_in = x; y_in = y; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: in_ready=%0b busy=%0b required 0/1", tag, in_ready, busy);
        end
        cnt = 0;
        while (!out_valid && cnt < 30) begin
            if (poke && cnt == 2) begin
                in_valid = 1'b1; x_in = ~x; y_in = ~y; b_in = ~b;
            end
            if (poke && cnt == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            cnt++;
        end
        in_valid = 1'b0;
        total++;
        if (cnt != N) begin
            bad++;
            $display("FAIL %s latency: got=%0d required=%0d", tag, cnt, N);
        end
        total++;
        if (x_out !== ex || y_out !== ey) begin
            bad++;
            $display("FAIL %s result: x_out=%06h y_out=%06h required x=%06h y=%06h", tag, x_out, y_out, ex, ey);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== ex || y_out !== ey) begin
                bad++;
                $display("FAIL %s hold%0d: out_valid=%0b in_ready=%0b x=%06h y=%06h required 1/0 x=%06h y=%06h",
                         tag, i, out_valid, in_ready, x_out, y_out, ex, ey);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0/1", tag, out_valid, in_ready);
        end
        $display("txn %s: x_in=%06h y_in=%06h b=%02h -> x_out=%06h y_out=%06h (exp %06h %06h) hold=%0d",
                 tag, x, y, b, x_out, y_out, ex, ey, hold);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || step !== 3'd0 ||
            x_out !== '0 || y_out !== '0) begin
            bad++;
            $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b step=%0d x=%06h y=%06h",
                     in_ready, out_valid, busy, step, x_out, y_out);
        end
        $display("txn reset: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_txn(22'h100000, 22'h000000, 8'h80, 22'h100000, 22'h000800, 0, 1'b0, "single_bit");
        run_txn(22'h100000, 22'h000000, 8'hFF, 22'h100000, 22'h000FF0, 0, 1'b0, "all_dirs");
        run_txn(22'h1FFFFF, 22'h200000, 8'h80, 22'h1FFFFF, 22'h200FFF, 0, 1'b0, "saturation");
        run_txn(22'h3FFC00, 22'h000400, 8'h00, 22'h3FFC00, 22'h000400, 0, 1'b0, "zero_dirs");
        run_txn(22'h3FFC00, 22'h000400, 8'h80, 22'h3FFBFE, 22'h0003FE, 0, 1'b0, "negative");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ex, ey;
        model(22'h0ABCDE, 22'h3F1234, 8'hA5, ex, ey);
        run_txn(22'h0ABCDE, 22'h3F1234, 8'hA5, ex, ey, 5, 1'b1, "backpressure");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ex, ey;
        wait_ready("reset_mid");
        out_ready = 1'b1;
        x_in = 22'h123456; y_in = 22'h054321; b_in = 8'hC3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        total++;
        if (step !== 3'd4) begin
            bad++;
            $display("FAIL reset_mid step: got=%0d required=4", step);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || step !== 3'd0 ||
            x_out !== '0 || y_out !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: out_valid=%0b in_ready=%0b busy=%0b step=%0d x=%06h y=%06h",
                     out_valid, in_ready, busy, step, x_out, y_out);
        end
        $display("txn reset_mid: out_valid=%0b in_ready=%0b x=%06h y=%06h", out_valid, in_ready, x_out, y_out);
        @(negedge clk);
        rst_n = 1'b1;
        model(22'h2A0F0F, 22'h01F0F0, 8'h5A, ex, ey);
        run_txn(22'h2A0F0F, 22'h01F0F0, 8'h5A, ex, ey, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ex, ey;
        int cnt;
        model(22'h0FFFFF, 22'h300001, 8'h3C, ex, ey);
        wait_ready("b2b");
        out_ready = 1'b1;
        x_in = 22'h0FFFFF; y_in = 22'h300001; b_in = 8'h3C; in_valid = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!(out_valid && cnt > 1) && cnt < 40);
        in_valid = 1'b0;
        total++;
        if (cnt != N + 2) begin
            bad++;
            $display("FAIL b2b period: got=%0d required=%0d", cnt, N + 2);
        end
        total++;
        if (x_out !== ex || y_out !== ey) begin
            bad++;
            $display("FAIL b2b result: x=%06h y=%06h required %06h %06h", x_out, y_out, ex, ey);
        end
        $display("txn b2b: period=%0d x_out=%06h y_out=%06h", cnt, x_out, y_out);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, ex, ey;
        logic [N-1:0] b;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: x = 22'h1FFFFF;
                1: x = 22'h200000;
                default: x = W'($urandom());
            endcase
            case ($urandom_range(0, 3))
                0: y = 22'h1FFFFF;
                1: y = 22'h200000;
                default: y = W'($urandom());
            endcase
            b = N'($urandom());
            model(x, y, b, ex, ey);
            run_txn(x, y, b, ex, ey, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
